// File: rtl/imem_loader_pkg.sv
// Shared constants and state types for the UART instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHK state for a trailing XOR checksum byte.
package imem_loader_pkg;
  localparam int LEN_BYTES            = 2;
  localparam int BYTES_PER_WORD       = 4;
  localparam int CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [2:0] {
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHK,
`endif
    ST_DONE,
    ST_ERROR
  } load_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;
endpackage

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, start-glitch rejection.
// byte_valid / framing_err are single-cycle pulses in the stop-bit sample cycle.
module uart_rx
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       framing_err
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= RX_START;
            cnt   <= HALF;
          end
        end
        RX_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_sync) begin
            state <= RX_IDLE;   // start bit vanished: treat as a glitch
          end else begin
            state   <= RX_DATA;
            cnt     <= FULL;
            bit_idx <= '0;
          end
        end
        RX_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shift   <= {rx_sync, shift[7:1]};
            cnt     <= FULL;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign data_byte   = shift;
  assign byte_valid  = (state == RX_STOP) && (cnt == '0) && rx_sync;
  assign framing_err = (state == RX_STOP) && (cnt == '0) && !rx_sync;
endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian word image from UART into instruction memory,
// holding the CPU in reset until done. IMEM_LOADER_CHECKSUM_EN enables the XOR checksum byte.
//   state    | meaning
//   LEN0     | waiting for word-count low byte
//   LEN1     | waiting for word-count high byte, range check
//   DATA     | assembling words, strobing memory writes
//   CHK      | waiting for checksum byte (checksum build only)
//   DONE     | image accepted, CPU released; a new byte restarts the load
//   ERROR    | terminal until reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int IMEM_DEPTH   = 512,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx,
  output logic             ins_mem_en,
  output logic [WIDTH-1:0] ins_mem_addr,
  output logic [WIDTH-1:0] ins_mem_data,
  output logic             cpu_reset,
  output logic             done,
  output logic             error
);
  localparam logic [16:0] DEPTH_L  = 17'(IMEM_DEPTH);
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic        framing_err;
  load_state_t state;
  logic [7:0]  len_lo;
  logic [15:0] len_word;
  logic [15:0] last_idx;
  logic [1:0]  byte_cnt;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .data_byte   (rx_byte),
    .byte_valid  (byte_valid),
    .framing_err (framing_err)
  );

  assign len_word = {rx_byte, len_lo};

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] chk;

  // Running XOR of every byte of the current load, seeded by the first count byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      chk <= '0;
    end else if (byte_valid) begin
      chk <= (state == ST_LEN0 || state == ST_DONE) ? rx_byte : (chk ^ rx_byte);
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_LEN0;
      len_lo       <= '0;
      last_idx     <= '0;
      byte_cnt     <= '0;
      ins_mem_en   <= 1'b0;
      ins_mem_addr <= '0;
      ins_mem_data <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      ins_mem_en <= 1'b0;
      if (framing_err && state != ST_ERROR) begin
        state     <= ST_ERROR;
        error     <= 1'b1;
        cpu_reset <= 1'b1;
        done      <= 1'b0;
      end else begin
        case (state)
          ST_LEN0: begin
            if (byte_valid) begin
              len_lo <= rx_byte;
              state  <= ST_LEN1;
            end
          end
          ST_LEN1: begin
            if (byte_valid) begin
              if (len_word == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= ST_CHK;
`else
                state     <= ST_DONE;
                done      <= 1'b1;
                cpu_reset <= 1'b0;
`endif
              end else if ({1'b0, len_word} > DEPTH_L) begin
                state <= ST_ERROR;
                error <= 1'b1;
              end else begin
                state        <= ST_DATA;
                last_idx     <= len_word - 16'd1;
                byte_cnt     <= '0;
                ins_mem_addr <= '0;
              end
            end
          end
          ST_DATA: begin
            if (ins_mem_en) begin
              // Cycle after a strobe: advance address, leave after the last word.
              ins_mem_addr <= ins_mem_addr + WIDTH'(1);
              if (ins_mem_addr == WIDTH'(last_idx)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= ST_CHK;
`else
                state     <= ST_DONE;
                done      <= 1'b1;
                cpu_reset <= 1'b0;
`endif
              end
            end else if (byte_valid) begin
              ins_mem_data <= {rx_byte, ins_mem_data[WIDTH-1:8]};
              byte_cnt     <= byte_cnt + 2'd1;
              if (byte_cnt == LAST_BYTE) ins_mem_en <= 1'b1;
            end
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          ST_CHK: begin
            if (byte_valid) begin
              if (rx_byte == chk) begin
                state     <= ST_DONE;
                done      <= 1'b1;
                cpu_reset <= 1'b0;
              end else begin
                state <= ST_ERROR;
                error <= 1'b1;
              end
            end
          end
`endif
          ST_DONE: begin
            if (byte_valid) begin
              len_lo       <= rx_byte;
              state        <= ST_LEN1;
              cpu_reset    <= 1'b1;
              done         <= 1'b0;
              ins_mem_addr <= '0;
            end
          end
          ST_ERROR: ;
          default: begin
            state <= ST_ERROR;
            error <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader with CLKS_PER_BIT=4.
// Expected strobes are queued from a byte-stream model; a monitor pops them on each strobe.
module tb_imem_loader;
  localparam int CPB   = 4;
  localparam int WIDTH = 32;
  localparam int DEPTH = 512;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             rx = 1'b1;
  logic             ins_mem_en;
  logic [WIDTH-1:0] ins_mem_addr;
  logic [WIDTH-1:0] ins_mem_data;
  logic             cpu_reset;
  logic             done;
  logic             error;

  imem_loader #(.WIDTH(WIDTH), .IMEM_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .ins_mem_en   (ins_mem_en),
    .ins_mem_addr (ins_mem_addr),
    .ins_mem_data (ins_mem_data),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] words_q[$];
  logic        en_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clock) begin
    if (!reset && ins_mem_en) begin
      if (exp_addr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe actual addr=0x%0h data=0x%0h required=no strobe",
                 ins_mem_addr, ins_mem_data);
      end else begin
        check("strobe_addr", ins_mem_addr, exp_addr_q.pop_front());
        check("strobe_data", ins_mem_data, exp_data_q.pop_front());
      end
      check("strobe_one_cycle", {31'd0, en_prev}, 32'd0);
    end
    en_prev = ins_mem_en;
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_en"},        {31'd0, ins_mem_en}, 32'd0);
    check({tag, "_addr"},      ins_mem_addr, 32'd0);
    check({tag, "_data"},      ins_mem_data, 32'd0);
    check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
    check({tag, "_done"},      {31'd0, done}, 32'd0);
    check({tag, "_error"},     {31'd0, error}, 32'd0);
  endtask

  task automatic check_status(input string tag, input bit exp_done, input bit exp_err);
    check({tag, "_done"},      {31'd0, done}, {31'd0, exp_done});
    check({tag, "_error"},     {31'd0, error}, {31'd0, exp_err});
    check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, !exp_done});
  endtask

  // Model: build the byte stream for n words from words_q, queue the strobes the
  // loader must produce, send it (truncated at a bad-stop byte), then check status.
  task automatic run_load(input string tag, input int n, input int bad_idx,
                          input logic [7:0] chk_flip);
    logic [7:0] bytes_q[$];
    logic [7:0] x;
    bit         err;
    err = (bad_idx >= 0);
    bytes_q.push_back(8'(n));
    bytes_q.push_back(8'(n >> 8));
    if (n > DEPTH) begin
      err = 1'b1;
    end else begin
      for (int j = 0; j < n; j++)
        for (int k = 0; k < 4; k++) bytes_q.push_back(8'(words_q[j] >> (8 * k)));
      x = 8'h00;
      foreach (bytes_q[i]) x ^= bytes_q[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
      bytes_q.push_back(x ^ chk_flip);
      if (chk_flip != 8'h00) err = 1'b1;
`endif
      for (int j = 0; j < n; j++)
        if (bad_idx < 0 || 4 * j + 5 < bad_idx) begin
          exp_addr_q.push_back(32'(j));
          exp_data_q.push_back(words_q[j]);
        end
    end
    foreach (bytes_q[i])
      if (bad_idx < 0 || i <= bad_idx) send_byte(bytes_q[i], i == bad_idx);
    repeat (12) @(negedge clock);
    check({tag, "_strobes_left"}, 32'(exp_addr_q.size()), 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    check_status(tag, !err, err);
  endtask

  initial begin
    int n;
    repeat (4) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_status("idle_len0", 1'b0, 1'b0);

    // V1
    words_q = '{32'h0000_0013, 32'hDEAD_BEEF};
    run_load("v1", 2, -1, 8'h00);

    // V4: one-cycle low glitch while in DONE
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (20) @(negedge clock);
    check_status("v4_glitch", 1'b1, 1'b0);

    // Random restarts from DONE
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 5));
      words_q.delete();
      for (int j = 0; j < n; j++) words_q.push_back($urandom);
      run_load("rand", n, -1, 8'h00);
    end

    // Empty image
    words_q.delete();
    run_load("n0", 0, -1, 8'h00);

    // V2: N = 513
    apply_reset();
    run_load("v2", 513, -1, 8'h00);

    // V3: framing error on 3rd byte, sticky
    apply_reset();
    words_q = '{32'h1234_5678};
    run_load("v3", 1, 2, 8'h00);
    send_byte(8'h55, 1'b0);
    repeat (4) @(negedge clock);
    check_status("v3_sticky", 1'b0, 1'b1);
    apply_reset();
    check_status("v3_cleared", 1'b0, 1'b0);

    // V5: reset mid-word, then clean reload
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_values("v5_reset");
    reset = 1'b0;
    repeat (2) @(negedge clock);
    words_q = '{32'hA5A5_A5A5};
    run_load("v5_reload", 1, -1, 8'h00);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // V6: checksum 0x05 accepted, 0x06 rejected
    apply_reset();
    words_q = '{32'h0102_0304};
    run_load("v6_good", 1, -1, 8'h00);
    apply_reset();
    run_load("v6_bad", 1, -1, 8'h03);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
